// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/grant and slave response signals of the shared two-master bus
interface bus_arbiter_rr_if #(parameter int BURST_W = 4);
  logic busreq_1;
  logic busreq_2;
  logic [BURST_W-1:0] len_1;
  logic [BURST_W-1:0] len_2;
  logic ready;
  logic [1:0] response;
  logic [1:0] split_clr;
  logic grant_1;
  logic grant_2;
  logic owner;
  logic active;
  logic error;
  logic [1:0] split_mask;
  modport master (
    output busreq_1, busreq_2, len_1, len_2, ready, response, split_clr,
    input  grant_1, grant_2, owner, active, error, split_mask
  );
  modport slave (
    input  busreq_1, busreq_2, len_1, len_2, ready, response, split_clr,
    output grant_1, grant_2, owner, active, error, split_mask
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin bus arbiter with burst sequencing, split masking and ready timeout
module bus_arbiter_rr #(
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  bus_arbiter_rr_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2;
  logic [1:0] state;
  logic [BURST_W-1:0] beat;
  logic [TW-1:0] tcnt;
  logic last;
  logic [1:0] elig;
  logic pick;
  logic done;
  logic exit_d;
  logic [1:0] set_m;
  always_comb begin
    elig = {bus.busreq_2, bus.busreq_1} & ~bus.split_mask;
    pick = (elig == 2'b11) ? ~last : elig[1];
    done = bus.ready ? (bus.response != 2'b00 || beat == '0) : (tcnt == TW'(TIMEOUT - 1));
    exit_d = (state == S_DATA) && done;
    set_m = (exit_d && bus.ready && bus.response == 2'b11) ? (bus.owner ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      beat <= '0;
      tcnt <= '0;
      last <= 1'b1;
      bus.grant_1 <= 1'b0;
      bus.grant_2 <= 1'b0;
      bus.owner <= 1'b0;
      bus.active <= 1'b0;
      bus.error <= 1'b0;
      bus.split_mask <= 2'b00;
    end else begin
      bus.error <= exit_d && (bus.ready ? bus.response == 2'b01 : 1'b1);
      // a SPLIT arriving with a clear of the same bit must keep the master parked
      bus.split_mask <= (bus.split_mask & ~bus.split_clr) | set_m;
      if (state == S_IDLE && elig != 2'b00) begin
        state <= S_ADDR;
        bus.grant_1 <= ~pick;
        bus.grant_2 <= pick;
        bus.owner <= pick;
        bus.active <= 1'b1;
      end else if (state == S_ADDR) begin
        state <= S_DATA;
        beat <= bus.owner ? bus.len_2 : bus.len_1;
        tcnt <= '0;
      end else if (exit_d) begin
        state <= S_IDLE;
        bus.grant_1 <= 1'b0;
        bus.grant_2 <= 1'b0;
        bus.active <= 1'b0;
        last <= bus.owner;
      end else if (state == S_DATA) begin
        tcnt <= bus.ready ? '0 : tcnt + 1'b1;
        beat <= bus.ready ? beat - 1'b1 : beat;
      end
    end
  end
endmodule
